// File: rtl/ct_f_spsram_arb_pkg.sv
// Shared types and default sizes for the two-port single-port-SRAM arbiter.
package ct_f_spsram_arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned BYTE_LANES_DEF = DATA_WIDTH_DEF / 8;

    // ARB: serve requesters; INIT: sweep the array writing zeros.
    typedef enum logic {
        ARB  = 1'b0,
        INIT = 1'b1
    } state_t;

endpackage

// File: rtl/ct_f_rr_arb2.sv
// Two-way round-robin arbiter; pointer holds the last granted requester.
module ct_f_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic r_last;

    // Grant the sole requester, or on conflict the one not granted last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer moves only when a grant is actually issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            r_last <= gnt[1];
        end
    end

endmodule

// File: rtl/ct_f_spsram_arb.sv
// Arbitrates two requesters onto one single-port SRAM and provides an array clear.
module ct_f_spsram_arb
    import ct_f_spsram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req0_vld,
    output logic                    req0_rdy,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic                    req0_wr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_be,
    input  logic                    req1_vld,
    output logic                    req1_rdy,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic                    req1_wr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_be,
    output logic                    rsp0_vld,
    output logic                    rsp1_vld,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    input  logic                    init_start,
    output logic                    init_busy,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   A,
    output logic                    CEN,
    output logic                    GWEN,
    output logic [DATA_WIDTH-1:0]   WEN,
    output logic [DATA_WIDTH-1:0]   D,
    input  logic [DATA_WIDTH-1:0]   Q
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  r_rsp0_vld;
    logic                  r_rsp1_vld;
    logic                  r_init_done;
    logic                  w_done_nxt;
    logic                  w_arb_en;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BE_W-1:0]       w_be;
    logic [DATA_WIDTH-1:0] w_wen_wr;

    // Grants are allowed only in ARB, outside reset, and when no clear is being started.
    assign w_arb_en = (r_state == ARB) && !init_start && !RST;
    assign w_req    = {req1_vld, req0_vld} & {2{w_arb_en}};

    ct_f_rr_arb2 u_rr (
        .clk    (CLK),
        .rst    (RST),
        .req    (w_req),
        .update (w_arb_en),
        .gnt    (w_gnt)
    );

    assign req0_rdy = w_gnt[0];
    assign req1_rdy = w_gnt[1];

    // Select the granted requester's payload and expand byte enables to a bit mask.
    always_comb begin
        w_addr   = w_gnt[1] ? req1_addr  : req0_addr;
        w_wr     = w_gnt[1] ? req1_wr    : req0_wr;
        w_wdata  = w_gnt[1] ? req1_wdata : req0_wdata;
        w_be     = w_gnt[1] ? req1_be    : req0_be;
        w_wen_wr = '1;
        for (int unsigned i = 0; i < BE_W; i++) begin
            w_wen_wr[8*i +: 8] = {8{~w_be[i]}};
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, clear counter and SRAM pin drive.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        CEN         = 1'b1;
        GWEN        = 1'b1;
        WEN         = '1;
        A           = '0;
        D           = '0;
        case (r_state)
            ARB: begin
                if (init_start) begin
                    w_state_nxt = INIT;
                    w_cnt_nxt   = '0;
                end else if (w_gnt != 2'b00) begin
                    CEN = 1'b0;
                    A   = w_addr;
                    if (w_wr) begin
                        GWEN = 1'b0;
                        WEN  = w_wen_wr;
                        D    = w_wdata;
                    end
                end
            end
            INIT: begin
                CEN       = 1'b0;
                GWEN      = 1'b0;
                WEN       = '0;
                D         = '0;
                A         = r_cnt;
                w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = ARB;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // Clear counter, response tags and done pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt       <= '0;
            r_rsp0_vld  <= 1'b0;
            r_rsp1_vld  <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_rsp0_vld  <= w_gnt[0] & ~req0_wr;
            r_rsp1_vld  <= w_gnt[1] & ~req1_wr;
            r_init_done <= w_done_nxt;
        end
    end

    assign rsp0_vld  = r_rsp0_vld;
    assign rsp1_vld  = r_rsp1_vld;
    assign rsp_rdata = (r_rsp0_vld || r_rsp1_vld) ? Q : '0;
    assign init_busy = (r_state == INIT);
    assign init_done = r_init_done;

endmodule
